// File: rtl/cpu_pkg.sv
// Shared datapath sizing for the register file family.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int REG_DATA_W = 8;
  localparam int REG_ADDR_W = 2;
  localparam int REG_DEPTH  = 2 ** REG_ADDR_W;

  function automatic int depthOf(input int addrW);
    return 1 << addrW;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: bank mux, same-cycle write bypass, zero-register mask.
// Latency: zero cycles (purely combinational).
// Backpressure: none; the port is always ready.
module regfile_rdport
  import cpu_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic [DATA_W-1:0] bank [depthOf(ADDR_W)],
  input  logic [ADDR_W-1:0] readAddr,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  output logic [DATA_W-1:0] readData
);

  // Zero-register masking is applied last so it overrides the bypass.
  always_comb begin
    readData = bank[readAddr];
    if (BYPASS != 0 && wrEn && wrAddr == readAddr) begin
      readData = wrData;
    end
    if (ZERO_REG != 0 && readAddr == '0) begin
      readData = '0;
    end
  end

endmodule

// File: rtl/regfile_shadow.sv
// 2-read/1-write register file with a one-deep shadow bank for context save/restore.
// Latency: reads combinational (optional write bypass); writes, Save and Restore take one edge.
// Backpressure: none; every request is accepted on the edge it is presented.
module regfile_shadow
  import cpu_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteR,
  input  logic [DATA_W-1:0] WriteD,
  input  logic [ADDR_W-1:0] Read1,
  input  logic [ADDR_W-1:0] Read2,
  output logic [DATA_W-1:0] ReadD1,
  output logic [DATA_W-1:0] ReadD2,
  input  logic              Save,
  input  logic              Restore,
  output logic              ShadowValid,
  output logic              RestoreErr
);

  localparam int DEPTH = depthOf(ADDR_W);

  logic [DATA_W-1:0] live       [DEPTH];
  logic [DATA_W-1:0] shadow     [DEPTH];
  logic [DATA_W-1:0] liveNext   [DEPTH];
  logic [DATA_W-1:0] shadowNext [DEPTH];
  logic              shadowValidQ;
  logic              restoreErrQ;
  logic              doRestore;
  logic              bypassEn;

  assign doRestore = Restore & shadowValidQ;
  // Keeps the bypass from leaking WriteD onto the read ports while reset is held.
  assign bypassEn  = RegWrite & rst_n;

  // Save and Restore both read pre-edge banks, so asserting both is a clean swap.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      liveNext[i]   = doRestore ? shadow[i] : live[i];
      shadowNext[i] = Save ? live[i] : shadow[i];
      if (RegWrite && WriteR == ADDR_W'(i)) begin
        liveNext[i] = WriteD;
      end
      if (ZERO_REG != 0 && i == 0) begin
        liveNext[i]   = '0;
        shadowNext[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        live[i]   <= '0;
        shadow[i] <= '0;
      end
      shadowValidQ <= 1'b0;
      restoreErrQ  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        live[i]   <= liveNext[i];
        shadow[i] <= shadowNext[i];
      end
      shadowValidQ <= Save | (shadowValidQ & ~Restore);
      restoreErrQ  <= restoreErrQ | (Restore & ~shadowValidQ);
    end
  end

  assign ShadowValid = shadowValidQ;
  assign RestoreErr  = restoreErrQ;

  regfile_rdport #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) uRd1 (
    .bank(live), .readAddr(Read1), .wrEn(bypassEn),
    .wrAddr(WriteR), .wrData(WriteD), .readData(ReadD1)
  );

  regfile_rdport #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) uRd2 (
    .bank(live), .readAddr(Read2), .wrEn(bypassEn),
    .wrAddr(WriteR), .wrData(WriteD), .readData(ReadD2)
  );

endmodule

// File: tb/tb_regfile_shadow.sv
// Drives three configurations (default, no bypass, zero register) with shared stimulus
// and compares them against a bank-level reference model.
module tb_regfile_shadow;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       RegWrite = 1'b0, Save = 1'b0, Restore = 1'b0;
  logic [1:0] WriteR = '0, Read1 = '0, Read2 = '0;
  logic [7:0] WriteD = '0;
  logic [7:0] rdA1, rdA2, rdB1, rdB2, rdZ1, rdZ2;
  logic       svA, svB, svZ, erA, erB, erZ;

  int checks = 0;
  int failures = 0;

  // Model: config 0 = no zero register (A and B share it), config 1 = zero register (Z).
  logic [7:0] mLive   [2][4];
  logic [7:0] mShadow [2][4];
  bit         mValid;
  bit         mErr;

  always #5 clk = ~clk;

  regfile_shadow #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(0), .BYPASS(1)) dutA (
    .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .WriteR(WriteR), .WriteD(WriteD),
    .Read1(Read1), .Read2(Read2), .ReadD1(rdA1), .ReadD2(rdA2),
    .Save(Save), .Restore(Restore), .ShadowValid(svA), .RestoreErr(erA));

  regfile_shadow #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(0), .BYPASS(0)) dutB (
    .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .WriteR(WriteR), .WriteD(WriteD),
    .Read1(Read1), .Read2(Read2), .ReadD1(rdB1), .ReadD2(rdB2),
    .Save(Save), .Restore(Restore), .ShadowValid(svB), .RestoreErr(erB));

  regfile_shadow #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(1), .BYPASS(1)) dutZ (
    .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .WriteR(WriteR), .WriteD(WriteD),
    .Read1(Read1), .Read2(Read2), .ReadD1(rdZ1), .ReadD2(rdZ2),
    .Save(Save), .Restore(Restore), .ShadowValid(svZ), .RestoreErr(erZ));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] expRead(input int c, input bit byp, input logic [1:0] a);
    if (c == 1 && a == 2'd0) return 8'h00;
    if (byp && RegWrite && WriteR == a) return WriteD;
    return mLive[c][a];
  endfunction

  task automatic modelClear();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 4; i++) begin
        mLive[c][i]   = 8'h00;
        mShadow[c][i] = 8'h00;
      end
    mValid = 0;
    mErr   = 0;
  endtask

  task automatic modelEdge();
    logic [7:0] oL [4];
    logic [7:0] oS [4];
    bit v;
    v = mValid;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 4; i++) begin
        oL[i] = mLive[c][i];
        oS[i] = mShadow[c][i];
      end
      for (int i = 0; i < 4; i++) begin
        if (Save && Restore && v) begin
          mLive[c][i]   = oS[i];
          mShadow[c][i] = oL[i];
        end else if (Save) begin
          mShadow[c][i] = oL[i];
        end else if (Restore && v) begin
          mLive[c][i] = oS[i];
        end
      end
      if (RegWrite) mLive[c][WriteR] = WriteD;
      if (c == 1) begin
        mLive[1][0]   = 8'h00;
        mShadow[1][0] = 8'h00;
      end
    end
    if (Save) mValid = 1;
    else if (Restore) mValid = 0;
    if (Restore && !v) mErr = 1;
  endtask

  task automatic checkAll(input string tag);
    chk({tag, ".A1"}, rdA1, expRead(0, 1, Read1));
    chk({tag, ".A2"}, rdA2, expRead(0, 1, Read2));
    chk({tag, ".B1"}, rdB1, expRead(0, 0, Read1));
    chk({tag, ".B2"}, rdB2, expRead(0, 0, Read2));
    chk({tag, ".Z1"}, rdZ1, expRead(1, 1, Read1));
    chk({tag, ".Z2"}, rdZ2, expRead(1, 1, Read2));
    chk({tag, ".svA"}, {7'b0, svA}, {7'b0, mValid});
    chk({tag, ".svB"}, {7'b0, svB}, {7'b0, mValid});
    chk({tag, ".svZ"}, {7'b0, svZ}, {7'b0, mValid});
    chk({tag, ".erA"}, {7'b0, erA}, {7'b0, mErr});
    chk({tag, ".erB"}, {7'b0, erB}, {7'b0, mErr});
    chk({tag, ".erZ"}, {7'b0, erZ}, {7'b0, mErr});
  endtask

  // Presents one cycle of inputs, checks pre-edge outputs, then advances model and DUT.
  task automatic cycle(input string tag, input bit we, input logic [1:0] wr,
                       input logic [7:0] wd, input bit sv, input bit rs,
                       input logic [1:0] r1, input logic [1:0] r2);
    RegWrite = we; WriteR = wr; WriteD = wd; Save = sv; Restore = rs;
    Read1 = r1; Read2 = r2;
    #2;
    checkAll(tag);
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    chk({tag, ".A1"}, rdA1, 8'h00);
    chk({tag, ".A2"}, rdA2, 8'h00);
    chk({tag, ".B1"}, rdB1, 8'h00);
    chk({tag, ".Z2"}, rdZ2, 8'h00);
    chk({tag, ".sv"}, {7'b0, svA | svB | svZ}, 8'h00);
    chk({tag, ".er"}, {7'b0, erA | erB | erZ}, 8'h00);
  endtask

  // Asserts reset mid-cycle with a live write pending on a read-matched address.
  task automatic midReset(input string tag);
    RegWrite = 1'b1; WriteR = 2'd2; WriteD = 8'h5A; Read1 = 2'd2; Read2 = 2'd3;
    Save = 1'b0; Restore = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    modelClear();
    checkResetOutputs(tag);
    repeat (2) @(posedge clk);
    @(negedge clk);
    RegWrite = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    modelClear();
    #2;
    checkResetOutputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill R0..R3, reading R0 during its own write to hit bypass and zero-reg cases.
    cycle("w0", 1, 2'd0, 8'hAA, 0, 0, 2'd0, 2'd1);
    cycle("w1", 1, 2'd1, 8'hFF, 0, 0, 2'd0, 2'd1);
    cycle("w2", 1, 2'd2, 8'h11, 0, 0, 2'd2, 2'd0);
    cycle("w3", 1, 2'd3, 8'hAB, 0, 0, 2'd3, 2'd2);
    cycle("r01", 0, 2'd0, 8'h00, 0, 0, 2'd0, 2'd1);
    cycle("r23", 0, 2'd0, 8'h00, 0, 0, 2'd2, 2'd3);

    cycle("byp", 1, 2'd2, 8'h5C, 0, 0, 2'd2, 2'd2);
    cycle("aftbyp", 0, 2'd0, 8'h00, 0, 0, 2'd2, 2'd1);
    cycle("fix2", 1, 2'd2, 8'h11, 0, 0, 2'd0, 2'd3);

    cycle("saveW", 1, 2'd1, 8'h00, 1, 0, 2'd1, 2'd0);
    for (int i = 0; i < 4; i++) cycle("clr", 1, 2'(i), 8'h00, 0, 0, 2'(i), 2'd3);
    cycle("restore", 0, 2'd0, 8'h00, 0, 1, 2'd0, 2'd1);
    cycle("rst01", 0, 2'd0, 8'h00, 0, 0, 2'd0, 2'd1);
    cycle("rst23", 0, 2'd0, 8'h00, 0, 0, 2'd2, 2'd3);

    cycle("badRestore", 0, 2'd0, 8'h00, 0, 1, 2'd1, 2'd2);
    for (int i = 0; i < 10; i++) cycle("errHold", 0, 2'd0, 8'h00, 0, 0, 2'(i), 2'(i + 1));
    midReset("midRst");

    cycle("p5w0", 1, 2'd0, 8'hAA, 0, 0, 2'd0, 2'd1);
    cycle("p5w1", 1, 2'd1, 8'hFF, 0, 0, 2'd0, 2'd1);
    cycle("p5w2", 1, 2'd2, 8'h11, 0, 0, 2'd2, 2'd3);
    cycle("p5w3", 1, 2'd3, 8'hAB, 0, 0, 2'd2, 2'd3);
    cycle("p5save", 0, 2'd0, 8'h00, 1, 0, 2'd0, 2'd3);
    for (int i = 0; i < 4; i++) cycle("p5new", 1, 2'(i), 8'(i + 1), 0, 0, 2'(i), 2'd0);
    cycle("swapW", 1, 2'd3, 8'h77, 1, 1, 2'd3, 2'd0);
    cycle("sw01", 0, 2'd0, 8'h00, 0, 0, 2'd0, 2'd1);
    cycle("sw23", 0, 2'd0, 8'h00, 0, 0, 2'd2, 2'd3);
    cycle("swRestore", 0, 2'd0, 8'h00, 0, 1, 2'd0, 2'd1);
    cycle("sh01", 0, 2'd0, 8'h00, 0, 0, 2'd0, 2'd1);
    cycle("sh23", 0, 2'd0, 8'h00, 0, 0, 2'd2, 2'd3);
    cycle("svRsInvalid", 0, 2'd0, 8'h00, 1, 1, 2'd0, 2'd2);
    cycle("postSvRs", 0, 2'd0, 8'h00, 0, 0, 2'd1, 2'd3);

    for (int n = 0; n < 400; n++) begin
      cycle("rnd", 1'($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom),
            1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0),
            2'($urandom), 2'($urandom));
      if (n == 200) midReset("rndRst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
